// File: rtl/mem_arbiter_pkg.sv
// Shared FSM state encodings, access-width codes and owner tags for the memory arbiter.
// Latency: n/a (types only); backpressure: n/a.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Unused code 2'b11 is treated as a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      WIDTH_BYTE: width_bytes = 3'd1;
      WIDTH_HALF: width_bytes = 3'd2;
      default:    width_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and byte-RAM signals of the memory arbiter; slave = arbiter side, master = environment.
// Latency/backpressure: defined by mem_arbiter (req held until done, stall while waiting).
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_data;
  logic        if_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  logic        if_stall_req;
  logic        mem_stall_req;

  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, if_stall_req, mem_stall_req,
           ram_addr, ram_we, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, if_stall_req, mem_stall_req,
           ram_addr, ram_we, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests (data first, non-preemptive) onto a byte-wide synchronous RAM.
// Latency: read N+2, write N+1 cycles from grant (N=1/2/4 bytes); requesters stall until their done.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_e      state_q;
  owner_e      owner_q;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [23:0] rbuf_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic        if_done_q;
  logic        mem_done_q;
  logic [31:0] ram_addr_q;
  logic        ram_we_q;
  logic [7:0]  ram_dout_q;

  logic [2:0]  cnt_d;
  logic [31:0] rd_word_d;

  assign cnt_d = cnt_q + 3'd1;

  // The last byte is taken straight from ram_din on the edge that enters DONE.
  always_comb begin
    rd_word_d = 32'd0;
    case (n_q)
      3'd1:    rd_word_d = {24'd0, bus.ram_din};
      3'd2:    rd_word_d = {16'd0, bus.ram_din, rbuf_q[7:0]};
      default: rd_word_d = {bus.ram_din, rbuf_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 24'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q  <= 3'd0;
          rbuf_q <= 24'd0;
          if (bus.mem_req) begin
            owner_q    <= OWN_MEM;
            base_q     <= bus.mem_addr;
            n_q        <= width_bytes(bus.mem_width);
            wdata_q    <= bus.mem_wdata;
            ram_addr_q <= bus.mem_addr;
            ram_we_q   <= bus.mem_we;
            ram_dout_q <= bus.mem_we ? bus.mem_wdata[7:0] : 8'd0;
            state_q    <= bus.mem_we ? ST_WRITE : ST_READ;
          end else if (bus.if_req && !bus.if_flush) begin
            owner_q    <= OWN_IF;
            base_q     <= bus.if_addr;
            n_q        <= 3'd4;
            ram_addr_q <= bus.if_addr;
            state_q    <= ST_READ;
          end
        end

        ST_READ: begin
          if (owner_q == OWN_IF && bus.if_flush) begin
            ram_addr_q <= 32'd0;
            cnt_q      <= 3'd0;
            state_q    <= ST_IDLE;
          end else if (cnt_q == n_q) begin
            ram_addr_q <= 32'd0;
            cnt_q      <= 3'd0;
            state_q    <= ST_DONE;
            if (owner_q == OWN_MEM) begin
              mem_rdata_q <= rd_word_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_data_q <= rd_word_d;
              if_done_q <= 1'b1;
            end
          end else begin
            case (cnt_q)
              3'd1:    rbuf_q[7:0]   <= bus.ram_din;
              3'd2:    rbuf_q[15:8]  <= bus.ram_din;
              3'd3:    rbuf_q[23:16] <= bus.ram_din;
              default: ;
            endcase
            cnt_q      <= cnt_d;
            ram_addr_q <= (cnt_d == n_q) ? 32'd0 : base_q + {29'd0, cnt_d};
          end
        end

        ST_WRITE: begin
          if (cnt_d == n_q) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= 32'd0;
            ram_dout_q <= 8'd0;
            cnt_q      <= 3'd0;
            mem_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q      <= cnt_d;
            ram_addr_q <= base_q + {29'd0, cnt_d};
            ram_dout_q <= wdata_q[{cnt_d[1:0], 3'b000} +: 8];
          end
        end

        ST_DONE: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_data       = if_data_q;
  assign bus.if_done       = if_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.if_stall_req  = bus.if_req & ~if_done_q;
  assign bus.mem_stall_req = bus.mem_req & ~mem_done_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-002 SHALL have ports: if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_flush  in  1  cancel pending fetch.
REQ-003 SHALL have ports: if_data  out  32  fetched word; if_done  out  1  fetch complete.
REQ-004 SHALL have ports: mem_req  in  1  data request; mem_we  in  1  1=store; mem_addr  in  32  byte address; mem_width  in  2  00=byte, 01=half, 10=word; mem_wdata  in  32  store data.
REQ-005 SHALL have ports: mem_rdata  out  32  load data, zero-extended; mem_done  out  1  data access complete.
REQ-006 SHALL have ports: if_stall_req  out  1  stall fetch stage; mem_stall_req  out  1  stall MEM stage (drives pipeline mem_stall).
REQ-007 SHALL have ports: ram_addr  out  32  RAM byte address; ram_we  out  1  RAM write enable; ram_dout  out  8  RAM write byte; ram_din  in  8  RAM read byte, valid one cycle after ram_addr.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WRITE, DONE; requests sampled only in IDLE.
REQ-009 SHALL grant mem_req over if_req when both are high in IDLE (fixed priority, MEM first).
REQ-010 SHALL be non-preemptive: a granted transaction runs to DONE regardless of later requests.
REQ-011 SHALL latch address, width, we, wdata and owner at the grant edge; byte count N = 1, 2, 4; fetch always N=4.
REQ-012 READ, cycle k=0..N: ram_addr=base+k for k<N; for k>=1 capture ram_din into byte k-1; after k=N go to DONE.
REQ-013 WRITE, cycle k=0..N-1: ram_we=1, ram_addr=base+k, ram_dout=wdata[8k+7:8k]; after k=N-1 go to DONE.
REQ-014 Byte order SHALL be little-endian; unused upper load bytes SHALL read zero.
REQ-015 DONE SHALL last exactly one cycle, assert owner's done (Moore), hold data stable, grant nothing, then return to IDLE.
REQ-016 Requester SHALL drop req in the cycle after done; req still high in IDLE is a new request.
REQ-017 if_data/mem_rdata SHALL hold last completed value until the next completion of the same owner.
REQ-018 ram_we SHALL be 0 and ram_addr 0 outside READ/WRITE.
REQ-019 if_stall_req = if_req & ~if_done; mem_stall_req = mem_req & ~mem_done (combinational).
REQ-020 if_flush high while a fetch is in READ SHALL abort it: next state IDLE, no if_done.
REQ-021 if_flush in IDLE SHALL suppress granting a fetch that cycle; if_flush SHALL never affect data transactions.
REQ-022 Address arithmetic SHALL be 32-bit modulo; base+k wraps past 0xFFFFFFFF.
REQ-023 Latency: word read done 6 cycles after grant edge; byte read 3; word write 5; byte write 2.

Reset
REQ-024 rst SHALL force IDLE, counters 0, ram_we 0, ram_addr 0, ram_dout 0, if_data 0, mem_rdata 0, both done 0 at the next edge.
REQ-025 rst mid-WRITE SHALL deassert ram_we from the next cycle; partial writes are not undone.

Structure
REQ-026 State encodings and mem_width codes SHALL live in the shared defines include.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 Fetch 0x00000100, RAM bytes 11,22,33,44 -> if_data=0x44332211, if_done one cycle, 6 cycles after grant.
REQ-029 Simultaneous if_req and mem_req (load word 0x200) -> mem served first, fetch granted after DONE; if_stall_req high throughout.
REQ-030 Store half 0xABCD to 0x300 -> ram_we 2 cycles, bytes CD@0x300, AB@0x301; mem_done next cycle.
REQ-031 Load byte 0x80 from 0x401 -> mem_rdata=0x00000080.
REQ-032 if_flush at READ cycle 2 of fetch -> IDLE next cycle, if_done never asserted, pending mem_req granted.
REQ-033 rst at WRITE cycle 1 of word store -> ram_we 0 next cycle, all outputs at reset values.
